// File: rtl/counter_sequencer.sv
// counter_sequencer: run controller for a 6-bit slot counter; reloads it, issues prescaled ticks,
// counts 64-tick frames and flags any drift between issued ticks and the reported count.
module counter_sequencer #(
    parameter int PRESCALE_WIDTH = 8,
    parameter int FRAME_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      stop,
    input  logic                      hold,
    input  logic [PRESCALE_WIDTH-1:0] prescale,
    input  logic [FRAME_WIDTH-1:0]    num_frames,
    input  logic [5:0]                current_count,
    output logic                      counter_rst,
    output logic                      clk_enable,
    output logic                      busy,
    output logic                      frame_done,
    output logic                      all_done,
    output logic [FRAME_WIDTH-1:0]    frames_completed,
    output logic                      sync_error
);
    typedef enum logic [1:0] {IDLE, ARM, RUN} state_t;
    state_t state_q, state_d;
    logic [PRESCALE_WIDTH-1:0] div_q, div_d, presc_q, presc_d;
    logic [FRAME_WIDTH-1:0] nfr_q, nfr_d, frames_q, frames_d;
    logic [5:0] idx_q, idx_d, exp_count;
    logic act_q, act_d, clk_en_q, clk_en_d, crst_q, crst_d, busy_q, busy_d;
    logic fd_q, fd_d, ad_q, ad_d, serr_q, serr_d, frame_end;

    always_comb begin
        exp_count = (idx_q == 6'd0) ? 6'd63 : idx_q - 6'd1;
        frame_end = clk_en_q && (idx_q == 6'd63);
        state_d = state_q;
        presc_d = presc_q;
        nfr_d = nfr_q;
        frames_d = frames_q;
        idx_d = idx_q + 6'(clk_en_q);
        serr_d = serr_q | (clk_en_q && (current_count != exp_count));
        fd_d = 1'b0;
        ad_d = 1'b0;
        case (state_q)
            IDLE: if (start && !stop) begin
                state_d = ARM;
                presc_d = prescale;
                nfr_d = num_frames;
                frames_d = '0;
                serr_d = 1'b0;
            end
            ARM: begin
                idx_d = '0;
                state_d = stop ? IDLE : RUN;
            end
            RUN: begin
                if (frame_end && !stop) begin
                    frames_d = (&frames_q) ? frames_q : frames_q + FRAME_WIDTH'(1);
                    fd_d = 1'b1;
                    ad_d = (nfr_q != '0) && (frames_d == nfr_q);
                end
                state_d = (stop || ad_d) ? IDLE : RUN;
            end
            default: state_d = IDLE;
        endcase
        // act_q marks whether the divider advanced this cycle; held cycles freeze it
        div_d = (state_q == ARM || clk_en_q) ? '0 : div_q + PRESCALE_WIDTH'(act_q);
        act_d = (state_d == RUN) && !hold;
        clk_en_d = act_d && (div_d == presc_q);
        crst_d = state_d == ARM;
        busy_d = state_d != IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            div_q <= '0;
            presc_q <= '0;
            nfr_q <= '0;
            frames_q <= '0;
            idx_q <= '0;
            act_q <= 1'b0;
            clk_en_q <= 1'b0;
            crst_q <= 1'b0;
            busy_q <= 1'b0;
            fd_q <= 1'b0;
            ad_q <= 1'b0;
            serr_q <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q <= div_d;
            presc_q <= presc_d;
            nfr_q <= nfr_d;
            frames_q <= frames_d;
            idx_q <= idx_d;
            act_q <= act_d;
            clk_en_q <= clk_en_d;
            crst_q <= crst_d;
            busy_q <= busy_d;
            fd_q <= fd_d;
            ad_q <= ad_d;
            serr_q <= serr_d;
        end
    end

    assign counter_rst = crst_q;
    assign clk_enable = clk_en_q;
    assign busy = busy_q;
    assign frame_done = fd_q;
    assign all_done = ad_q;
    assign frames_completed = frames_q;
    assign sync_error = serr_q;
endmodule

// File: tb/tb_counter_sequencer.sv
// tb_counter_sequencer: directed and random runs checked every cycle against a countdown-based run model.
module tb_counter_sequencer;
    localparam int PW = 8;
    localparam int FW = 8;
    localparam int FMAX = (1 << FW) - 1;

    logic clk = 1'b0, rst = 1'b1, start = 1'b0, stop = 1'b0, hold = 1'b0;
    logic [PW-1:0] prescale = '0;
    logic [FW-1:0] num_frames = '0;
    logic [5:0] current_count, cnt = 6'd63;
    logic inj = 1'b0, inj_req = 1'b0;
    logic counter_rst, clk_enable, busy, frame_done, all_done, sync_error;
    logic [FW-1:0] frames_completed;

    int total = 0, bad = 0, cyc = 0;
    bit chk_en = 1'b0;
    int m_mode = 0, m_wait = 0, m_ticks = 0, m_p = 0, m_n = 0, e_frames = 0;
    bit e_crst = 0, e_clk = 0, e_busy = 0, e_fd = 0, e_ad = 0, e_serr = 0, fin;
    int n_ce = 0, n_fd = 0, n_ad = 0, last_fd = 0, prev_fd = 0, crst_cyc = 0, first_ce = 0;
    bit ce_pend = 0, fd_busy = 0;

    always #5 clk = ~clk;
    assign current_count = inj ? 6'd5 : cnt;

    counter_sequencer #(.PRESCALE_WIDTH(PW), .FRAME_WIDTH(FW)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .hold(hold),
        .prescale(prescale), .num_frames(num_frames), .current_count(current_count),
        .counter_rst(counter_rst), .clk_enable(clk_enable), .busy(busy),
        .frame_done(frame_done), .all_done(all_done),
        .frames_completed(frames_completed), .sync_error(sync_error)
    );

    task automatic chk(input string nm, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, req, $time);
        end
    endtask

    // Model: wait counts down active cycles to the next tick; ticks counts ticks of the run.
    always @(posedge clk) begin
        cyc++;
        fin = 0;
        if (e_clk) begin
            if (int'(current_count) != ((m_ticks % 64) == 0 ? 63 : (m_ticks % 64) - 1)) e_serr = 1;
            m_ticks++;
            fin = (m_ticks % 64) == 0;
        end
        e_crst = 0; e_clk = 0; e_fd = 0; e_ad = 0;
        if (rst) begin
            m_mode = 0; e_frames = 0; e_serr = 0; m_ticks = 0;
        end else if (m_mode == 0) begin
            if (start && !stop) begin
                m_mode = 1; m_p = int'(prescale); m_n = int'(num_frames);
                e_frames = 0; e_serr = 0; e_crst = 1;
            end
        end else if (stop) begin
            m_mode = 0;
        end else if (m_mode == 1) begin
            m_mode = 2; m_ticks = 0; m_wait = m_p;
        end else if (fin) begin
            e_frames = (e_frames < FMAX) ? e_frames + 1 : FMAX;
            e_fd = 1;
            if (m_n != 0 && e_frames == m_n) begin
                e_ad = 1; m_mode = 0;
            end
        end
        if (m_mode == 2 && !hold) begin
            if (m_wait == 0) begin
                e_clk = 1; m_wait = m_p;
            end else m_wait--;
        end
        e_busy = m_mode != 0;
        // observed-event bookkeeping for the hand-computed timing checks
        if (counter_rst) begin crst_cyc = cyc; ce_pend = 1; end
        if (clk_enable) begin
            n_ce++;
            if (ce_pend) begin first_ce = cyc; ce_pend = 0; end
        end
        if (frame_done) begin n_fd++; prev_fd = last_fd; last_fd = cyc; fd_busy = busy; end
        if (all_done) n_ad++;
        chk_en <= 1'b1;
        cnt <= counter_rst ? 6'd63 : clk_enable ? cnt + 6'd1 : cnt;
        inj <= inj_req && e_clk && (m_ticks % 64) == 10;
    end

    always @(negedge clk) if (chk_en) begin
        chk("counter_rst", counter_rst, e_crst);
        chk("clk_enable", clk_enable, e_clk);
        chk("busy", busy, e_busy);
        chk("frame_done", frame_done, e_fd);
        chk("all_done", all_done, e_ad);
        chk("frames_completed", frames_completed, e_frames);
        chk("sync_error", sync_error, e_serr);
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic go(input int p, input int n, output int e);
        prescale = PW'(p);
        num_frames = FW'(n);
        start = 1'b1;
        e = cyc + 1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input int lim);
        for (int i = 0; i < lim && busy; i++) @(negedge clk);
        chk("run_ends", busy, 0);
        @(negedge clk);
    endtask

    initial begin
        int e, b_ce, b_fd, b_ad;
        step(3);
        chk("rst_busy", busy, 0);
        chk("rst_clk_enable", clk_enable, 0);
        chk("rst_frames", frames_completed, 0);
        chk("rst_sync", sync_error, 0);
        rst = 1'b0;
        step(2);
        // prescale 0, one frame
        b_ce = n_ce; b_fd = n_fd; b_ad = n_ad;
        go(0, 1, e);
        wait_idle(200);
        chk("t1_crst_ofs", crst_cyc - e, 1);
        chk("t1_first_ce_ofs", first_ce - e, 2);
        chk("t1_ticks", n_ce - b_ce, 64);
        chk("t1_fd_ofs", last_fd - e, 66);
        chk("t1_busy_at_done", fd_busy, 0);
        chk("t1_frames", frames_completed, 1);
        chk("t1_all_done", n_ad - b_ad, 1);
        chk("t1_sync", sync_error, 0);
        // prescale 3, two frames
        b_ce = n_ce; b_fd = n_fd; b_ad = n_ad;
        go(3, 2, e);
        wait_idle(700);
        chk("t2_first_ce_ofs", first_ce - e, 5);
        chk("t2_ticks", n_ce - b_ce, 128);
        chk("t2_fd_count", n_fd - b_fd, 2);
        chk("t2_fd_gap", last_fd - prev_fd, 256);
        chk("t2_fd_ofs", last_fd - e, 514);
        chk("t2_frames", frames_completed, 2);
        chk("t2_all_done", n_ad - b_ad, 1);
        // free-run, stopped after ~150 ticks
        b_ce = n_ce; b_fd = n_fd; b_ad = n_ad;
        go(0, 0, e);
        for (int i = 0; i < 400 && (n_ce - b_ce) < 150; i++) @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        chk("t3_ce_after_stop", clk_enable, 0);
        chk("t3_busy_after_stop", busy, 0);
        step(3);
        chk("t3_fd_count", n_fd - b_fd, 2);
        chk("t3_no_all_done", n_ad - b_ad, 0);
        chk("t3_frames", frames_completed, 2);
        // hold for 10 cycles mid-frame at prescale 1
        b_ce = n_ce;
        go(1, 1, e);
        step(40);
        hold = 1'b1;
        step(10);
        hold = 1'b0;
        wait_idle(300);
        chk("t4_ticks", n_ce - b_ce, 64);
        chk("t4_fd_ofs", last_fd - e, 140);
        // corrupted count on one tick
        b_ad = n_ad;
        inj_req = 1'b1;
        go(0, 1, e);
        wait_idle(200);
        inj_req = 1'b0;
        chk("t5_sync_set", sync_error, 1);
        chk("t5_frames", frames_completed, 1);
        chk("t5_run_completed", n_ad - b_ad, 1);
        go(0, 1, e);
        chk("t5_sync_cleared", sync_error, 0);
        wait_idle(200);
        chk("t5_sync_clean", sync_error, 0);
        // start+stop together while idle, then start while busy
        start = 1'b1; stop = 1'b1;
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
        chk("t6_stays_idle", busy, 0);
        chk("t6_no_reload", counter_rst, 0);
        b_ad = n_ad;
        go(0, 1, e);
        step(5);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle(200);
        chk("t6_restart_ignored", last_fd - e, 66);
        chk("t6_all_done", n_ad - b_ad, 1);
        // rst mid-run
        go(2, 0, e);
        step(30);
        rst = 1'b1;
        @(negedge clk);
        chk("t7_busy", busy, 0);
        chk("t7_clk_enable", clk_enable, 0);
        chk("t7_counter_rst", counter_rst, 0);
        chk("t7_frames", frames_completed, 0);
        rst = 1'b0;
        step(2);
        // random traffic
        for (int i = 0; i < 5000; i++) begin
            start = $urandom_range(0, 29) == 0;
            stop = $urandom_range(0, 499) == 0;
            if ($urandom_range(0, 19) == 0) hold = ~hold;
            rst = $urandom_range(0, 2999) == 0;
            prescale = PW'($urandom_range(0, 2));
            num_frames = FW'($urandom_range(0, 2));
            inj_req = (i % 1000) < 300;
            @(negedge clk);
        end
        start = 1'b0; stop = 1'b0; hold = 1'b0; rst = 1'b0; inj_req = 1'b0;
        step(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
